// File: rtl/mult_sequencer.sv
// Control FSM for a shift-and-add multiplier: captures operands, steps WIDTH add/shift cycles, holds done until acked.
// Optional MULT_SKIP_ZERO_EN: finish early once the multiplier register has shifted down to zero.
//
// state | meaning
// ------+----------------------------------------------------------
// IDLE  | waiting for inputdata_ready; iter_cnt holds last result
// LOAD  | one cycle, operands captured and product cleared
// CALC  | one add/shift iteration per cycle, iter_cnt counts them
// DONE  | product valid, waiting for result_ack
module mult_sequencer #(
  parameter  int WIDTH = 8,
  localparam int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inputdata_ready,
  input  logic             b_lsb,
  input  logic             mplr_zero,
  input  logic             result_ack,
  output logic             loaddata,
  output logic             add_en,
  output logic             shift_en,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] iter_cnt
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    CALC = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             skip;
  logic             last_iter;

`ifdef MULT_SKIP_ZERO_EN
  assign skip = mplr_zero;
`else
  logic unused_mplr_zero;
  assign unused_mplr_zero = mplr_zero;
  assign skip             = 1'b0;
`endif

  assign last_iter = (cnt_q == CNT_W'(WIDTH - 1));
  assign iter_cnt  = cnt_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (inputdata_ready) state_d = LOAD;
      end
      LOAD: begin
        cnt_d   = '0;
        state_d = CALC;
      end
      CALC: begin
        // A zero multiplier has no bits left to add, so the count is frozen where it stopped.
        if (skip) begin
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
          if (last_iter) state_d = DONE;
        end
      end
      DONE: begin
        // No DONE->LOAD path: a new op always passes through IDLE.
        if (result_ack) state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_comb begin
    loaddata = 1'b0;
    add_en   = 1'b0;
    shift_en = 1'b0;
    busy     = 1'b0;
    done     = 1'b0;
    case (state_q)
      LOAD: begin
        loaddata = 1'b1;
        busy     = 1'b1;
      end
      CALC: begin
        busy     = 1'b1;
        shift_en = ~skip;
        add_en   = b_lsb & ~skip;
      end
      DONE: begin
        done = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_mult_sequencer.sv
// Directed bench for mult_sequencer (WIDTH=8) with a behavioural multiplier shift register feeding b_lsb/mplr_zero.
// Build with MULT_SKIP_ZERO_EN defined to exercise the early-finish expectations.
module tb_mult_sequencer;

  logic       clk;
  logic       reset;
  logic       inputdata_ready;
  logic       b_lsb;
  logic       mplr_zero;
  logic       result_ack;
  logic       loaddata;
  logic       add_en;
  logic       shift_en;
  logic       busy;
  logic       done;
  logic [3:0] iter_cnt;

  logic [7:0] mplr;
  logic [7:0] op_mplr;

  int n_checks;
  int n_pass;

  mult_sequencer #(.WIDTH(8)) dut (
    .clk            (clk),
    .reset          (reset),
    .inputdata_ready(inputdata_ready),
    .b_lsb          (b_lsb),
    .mplr_zero      (mplr_zero),
    .result_ack     (result_ack),
    .loaddata       (loaddata),
    .add_en         (add_en),
    .shift_en       (shift_en),
    .busy           (busy),
    .done           (done),
    .iter_cnt       (iter_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Multiplier register of the datapath, driven by the DUT's enables.
  always @(posedge clk) begin
    if (loaddata)      mplr <= op_mplr;
    else if (shift_en) mplr <= mplr >> 1;
  end
  assign b_lsb     = mplr[0];
  assign mplr_zero = (mplr == 8'h00);

  // Starts an op from IDLE (caller is at a negedge) and samples each negedge until done.
  task automatic run_op(input logic [7:0] m, input bit stray_ack,
                        output int n_shift, output int n_load, output int n_add,
                        output logic [7:0] add_bits, output int done_at);
    op_mplr         = m;
    inputdata_ready = 1'b1;
    n_shift = 0; n_load = 0; n_add = 0; add_bits = 8'h00; done_at = -1;
    for (int i = 1; i <= 40 && done_at < 0; i++) begin
      @(negedge clk);
      inputdata_ready = 1'b0;
      if (loaddata) n_load++;
      if (add_en) n_add++;
      if (shift_en) begin
        if (n_shift < 8) add_bits[n_shift] = add_en;
        n_shift++;
      end
      result_ack = stray_ack && shift_en;
      if (done) done_at = i;
    end
  endtask

  task automatic finish_op();
    result_ack = 1'b1;
    @(negedge clk);
    result_ack = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0; inputdata_ready = 1'b0; result_ack = 1'b0;
    op_mplr = 8'h00; mplr = 8'h00;
    #3;
    n_checks++;
    if ({loaddata, add_en, shift_en, busy, done, iter_cnt} !== 9'd0)
      $display("FAIL reset_outputs got=%b want=0", {loaddata, add_en, shift_en, busy, done, iter_cnt});
    else n_pass++;
    @(negedge clk); reset = 1'b1;
    @(negedge clk);
    n_checks++;
    if ({loaddata, busy, done, iter_cnt} !== 7'd0)
      $display("FAIL reset_idle got=%b want=0", {loaddata, busy, done, iter_cnt});
    else n_pass++;
  endtask

  task automatic test_normal_op();
    int ns, nl, na, da; logic [7:0] ab;
    run_op(8'hA5, 1'b0, ns, nl, na, ab, da);
    n_checks++;
    if (nl !== 1) $display("FAIL normal_load_cycles got=%0d want=1", nl); else n_pass++;
    n_checks++;
    if (ns !== 8) $display("FAIL normal_shift_cycles got=%0d want=8", ns); else n_pass++;
    n_checks++;
    if (ab !== 8'hA5) $display("FAIL normal_add_seq got=%h want=a5", ab); else n_pass++;
    n_checks++;
    if (da !== 10) $display("FAIL normal_done_latency got=%0d want=10", da); else n_pass++;
    n_checks++;
    if (iter_cnt !== 4'd8) $display("FAIL normal_iter_cnt got=%0d want=8", iter_cnt); else n_pass++;
  endtask

  task automatic test_hold_done();
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      n_checks++;
      if ({done, loaddata, busy} !== 3'b100)
        $display("FAIL hold_done cyc=%0d got=%b want=100", i, {done, loaddata, busy});
      else n_pass++;
    end
    finish_op();
    n_checks++;
    if ({done, busy, loaddata} !== 3'b000)
      $display("FAIL ack_exit got=%b want=000", {done, busy, loaddata});
    else n_pass++;
    n_checks++;
    if (iter_cnt !== 4'd8) $display("FAIL idle_iter_hold got=%0d want=8", iter_cnt); else n_pass++;
  endtask

  task automatic test_back_to_back();
    int load_at[2]; int done_at[2]; int nl, nd; logic [2:0] idle11;
    nl = 0; nd = 0; idle11 = 3'b111;
    load_at = '{-1, -1}; done_at = '{-1, -1};
    op_mplr = 8'hA5; result_ack = 1'b1; inputdata_ready = 1'b1;
    for (int i = 1; i <= 22; i++) begin
      @(negedge clk);
      if (loaddata && nl < 2) begin load_at[nl] = i; nl++; end
      if (done && nd < 2) begin done_at[nd] = i; nd++; end
      if (i == 11) idle11 = {loaddata, busy, done};
      if (i == 22) inputdata_ready = 1'b0;
      else inputdata_ready = shift_en ? 1'($urandom_range(0, 1)) : 1'b1;
    end
    result_ack = 1'b0;
    n_checks++;
    if (load_at[0] !== 1 || load_at[1] !== 12)
      $display("FAIL b2b_load_times got=%0d,%0d want=1,12", load_at[0], load_at[1]);
    else n_pass++;
    n_checks++;
    if (done_at[0] !== 10 || done_at[1] !== 21)
      $display("FAIL b2b_done_times got=%0d,%0d want=10,21", done_at[0], done_at[1]);
    else n_pass++;
    n_checks++;
    if (idle11 !== 3'b000) $display("FAIL b2b_idle_gap got=%b want=000", idle11); else n_pass++;
    n_checks++;
    if ({busy, done} !== 2'b00) $display("FAIL b2b_final_idle got=%b want=00", {busy, done}); else n_pass++;
  endtask

  task automatic test_reset_mid_calc();
    bit found; int ns, nl, na, da; logic [7:0] ab;
    found = 1'b0;
    op_mplr = 8'hFF; inputdata_ready = 1'b1;
    for (int i = 0; i < 20 && !found; i++) begin
      @(negedge clk);
      inputdata_ready = 1'b0;
      if (shift_en && iter_cnt == 4'd4) found = 1'b1;
    end
    n_checks++;
    if (!found) $display("FAIL mid_calc_reach got=timeout want=iter_cnt 4"); else n_pass++;
    #2 reset = 1'b0;
    #1;
    n_checks++;
    if ({loaddata, add_en, shift_en, busy, done, iter_cnt} !== 9'd0)
      $display("FAIL async_reset got=%b want=0", {loaddata, add_en, shift_en, busy, done, iter_cnt});
    else n_pass++;
    @(negedge clk); reset = 1'b1;
    @(negedge clk);
    n_checks++;
    if ({busy, done, iter_cnt} !== 6'd0)
      $display("FAIL post_reset_idle got=%b want=0", {busy, done, iter_cnt});
    else n_pass++;
    run_op(8'hFF, 1'b0, ns, nl, na, ab, da);
    n_checks++;
    if (ns !== 8 || na !== 8 || da !== 10 || iter_cnt !== 4'd8)
      $display("FAIL post_reset_op got=shift%0d add%0d done%0d iter%0d want=8,8,10,8", ns, na, da, iter_cnt);
    else n_pass++;
    finish_op();
  endtask

  task automatic test_stray_ack();
    int ns, nl, na, da; logic [7:0] ab; bit got_done;
    result_ack = 1'b1;
    @(negedge clk);
    result_ack = 1'b0;
    n_checks++;
    if ({busy, done, loaddata} !== 3'b000)
      $display("FAIL idle_ack got=%b want=000", {busy, done, loaddata});
    else n_pass++;
    run_op(8'h81, 1'b1, ns, nl, na, ab, da);
    n_checks++;
    if (ns !== 8 || da !== 10 || ab !== 8'h81 || iter_cnt !== 4'd8)
      $display("FAIL calc_ack got=shift%0d done%0d add%h iter%0d want=8,10,81,8", ns, da, ab, iter_cnt);
    else n_pass++;
    inputdata_ready = 1'b1; result_ack = 1'b1;
    @(negedge clk);
    result_ack = 1'b0;
    n_checks++;
    if ({busy, done, loaddata} !== 3'b000)
      $display("FAIL done_no_bypass got=%b want=000", {busy, done, loaddata});
    else n_pass++;
    @(negedge clk);
    inputdata_ready = 1'b0;
    n_checks++;
    if (loaddata !== 1'b1) $display("FAIL load_after_idle got=%b want=1", loaddata); else n_pass++;
    got_done = 1'b0;
    for (int i = 0; i < 20 && !got_done; i++) begin
      @(negedge clk);
      if (done) got_done = 1'b1;
    end
    n_checks++;
    if (!got_done) $display("FAIL drain_done got=timeout want=done"); else n_pass++;
    finish_op();
  endtask

  task automatic test_skip_zero();
    int ns, nl, na, da; logic [7:0] ab;
    run_op(8'h03, 1'b0, ns, nl, na, ab, da);
`ifdef MULT_SKIP_ZERO_EN
    n_checks++;
    if (ns !== 2 || iter_cnt !== 4'd2 || da !== 5 || na !== 2)
      $display("FAIL skip_03 got=shift%0d iter%0d done%0d add%0d want=2,2,5,2", ns, iter_cnt, da, na);
    else n_pass++;
`else
    n_checks++;
    if (ns !== 8 || iter_cnt !== 4'd8 || da !== 10 || na !== 2)
      $display("FAIL noskip_03 got=shift%0d iter%0d done%0d add%0d want=8,8,10,2", ns, iter_cnt, da, na);
    else n_pass++;
`endif
    finish_op();
    run_op(8'h00, 1'b0, ns, nl, na, ab, da);
`ifdef MULT_SKIP_ZERO_EN
    n_checks++;
    if (ns !== 0 || iter_cnt !== 4'd0 || da !== 3)
      $display("FAIL skip_00 got=shift%0d iter%0d done%0d want=0,0,3", ns, iter_cnt, da);
    else n_pass++;
`else
    n_checks++;
    if (ns !== 8 || iter_cnt !== 4'd8 || da !== 10 || na !== 0)
      $display("FAIL noskip_00 got=shift%0d iter%0d done%0d add%0d want=8,8,10,0", ns, iter_cnt, da, na);
    else n_pass++;
`endif
    finish_op();
  endtask

  initial begin
    n_checks = 0;
    n_pass   = 0;
    test_reset();
    test_normal_op();
    test_hold_done();
    test_back_to_back();
    test_reset_mid_calc();
    test_stray_ack();
    test_skip_zero();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
